// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract sequencer.
package addsub_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   // Index width for a nibble counter: ceil(log2(n)), never less than 1 bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/nibble_cla_slice.sv
// 4-bit carry-lookahead adder slice; b arrives already inverted for subtraction.
module nibble_cla_slice
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout,
   output logic                c3
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W:0]   c;

   // Generate/propagate terms and flattened lookahead carries.
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
      sum  = p ^ c[NIBBLE_W-1:0];
      cout = c[4];
      c3   = c[3];
   end

endmodule

// File: rtl/serial_addsub_sequencer.sv
// Wide add/subtract streamed LSB nibble first through one lookahead slice.
module serial_addsub_sequencer
   import addsub_pkg::*;
#(
   parameter  int unsigned NIBBLES = 4,
   localparam int unsigned W       = NIBBLE_W * NIBBLES
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow
);

   localparam int unsigned IW = clog2(NIBBLES);

   seq_state_t           state_q, state_d;
   logic [W-1:0]         a_q, b_q;
   logic                 sub_q;
   logic                 carry_q;
   logic [IW-1:0]        idx_q;
   logic [W-1:0]         result_q;
   logic                 carry_out_q;
   logic                 overflow_q;

   logic                 load;
   logic                 last;
   logic [NIBBLE_W-1:0]  a_nib, b_nib, sum_nib;
   logic                 slice_cout, slice_c3;

   assign load = start && ((state_q == IDLE) || (state_q == DONE));
   assign last = (idx_q == IW'(NIBBLES - 1));

   // Select the current operand nibble; inverting b plus carry-in 1 forms -B.
   always_comb begin
      a_nib = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
      b_nib = b_q[idx_q * NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
   end

   nibble_cla_slice u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_q),
      .sum  (sum_nib),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: DONE with start relaunches directly for back-to-back use.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, carry chain and per-nibble result write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (load) begin
         a_q     <= a;
         b_q     <= b;
         sub_q   <= op_sub;
         carry_q <= op_sub;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         result_q[idx_q * NIBBLE_W +: NIBBLE_W] <= sum_nib;
         carry_q <= slice_cout;
         if (last) begin
            carry_out_q <= slice_cout;
            overflow_q  <= slice_c3 ^ slice_cout;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule
